// File: rtl/cdc_pkg.sv
// Shared types and helpers for the CDC event arbiter: arbiter state
// encoding and the channel-id width function.
package cdc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  // Width of a channel id; a single bit is kept even for tiny channel counts.
  function automatic int ch_width(input int num_ch);
    if (num_ch <= 2) begin
      return 1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/cdc_event_arbiter_if.sv
// Valid/ready event port carrying the id of the channel being offered.
// The arbiter drives through the master modport, the consumer through slave.
interface cdc_event_arbiter_if #(
  parameter int NUM_CH = 4
) ();

  localparam int CH_W = cdc_pkg::ch_width(NUM_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;

  modport master (
    output evt_valid,
    output evt_ch,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    output evt_ready
  );

endinterface

// File: rtl/cdc_event_arbiter_toggle_event_detector.sv
// Two-flop synchronizer plus history flop for one toggle-encoded request.
// Every level change of req_tgl yields a one-cycle evt once it has crossed.
// The whole chain freezes while enable is low so no toggle is dropped.
module toggle_event_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic req_tgl,
  output logic evt
);

  logic s1_r;
  logic s2_r;
  logic h_r;

  // Synchronize the foreign toggle and remember the previous synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      h_r  <= 1'b0;
    end else if (enable) begin
      s1_r <= req_tgl;
      s2_r <= s1_r;
      h_r  <= s2_r;
    end else begin
      s1_r <= s1_r;
      s2_r <= s2_r;
      h_r  <= h_r;
    end
  end

  // Both edges of the synchronized toggle are events.
  assign evt = enable & (s2_r ^ h_r);

endmodule

// File: rtl/cdc_event_arbiter.sv
// Receiving side of several toggle-encoded CDC event links. Each channel is
// synchronized, queued in a saturating pending counter, and served onto one
// valid/ready port in round-robin order. Each consumed event is returned to
// its source as a flip of ack_tgl.
module cdc_event_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   req_tgl,
  output logic [NUM_CH-1:0]   ack_tgl,
  output logic [NUM_CH-1:0]   overflow,
  input  logic                clr_overflow,
  cdc_event_arbiter_if.master evt_if
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]            evt_s;
  logic [NUM_CH-1:0]            dec_s;
  logic [NUM_CH-1:0]            pending_s;
  logic [NUM_CH-1:0]            ovf_set_s;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_r;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_nx_s;
  logic [NUM_CH-1:0]            overflow_r;
  logic [NUM_CH-1:0]            ovf_nx_s;
  logic [NUM_CH-1:0]            ack_tgl_r;
  logic [NUM_CH-1:0]            ack_nx_s;

  arb_state_e      state_r;
  arb_state_e      state_nx_s;
  logic            evt_valid_r;
  logic            valid_nx_s;
  logic [CH_W-1:0] evt_ch_r;
  logic [CH_W-1:0] ch_nx_s;
  logic [CH_W-1:0] last_grant_r;
  logic [CH_W-1:0] grant_nx_s;
  logic            hs_s;

  logic            found_s;
  logic [CH_W-1:0] sel_ch_s;
  logic [CH_W:0]   rr_sum_s;

  // Per-channel synchronizer and edge detector.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_det
    toggle_event_detector u_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .req_tgl (req_tgl[g]),
      .evt     (evt_s[g])
    );

    assign pending_s[g] = (cnt_r[g] != CNT_ZERO);
    assign dec_s[g]     = hs_s & (evt_ch_r == CH_W'(g));
  end

  assign hs_s = (state_r == ST_OFFER) & evt_valid_r & evt_if.evt_ready;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found_s  = 1'b0;
    sel_ch_s = {CH_W{1'b0}};
    rr_sum_s = {(CH_W + 1){1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_sum_s = {1'b0, last_grant_r} + (CH_W + 1)'(k);
      if (rr_sum_s >= (CH_W + 1)'(NUM_CH)) begin
        rr_sum_s = rr_sum_s - (CH_W + 1)'(NUM_CH);
      end else begin
        rr_sum_s = rr_sum_s;
      end
      if (!found_s && pending_s[rr_sum_s[CH_W-1:0]]) begin
        found_s  = 1'b1;
        sel_ch_s = rr_sum_s[CH_W-1:0];
      end else begin
        found_s  = found_s;
        sel_ch_s = sel_ch_s;
      end
    end
  end

  // Pending counters: +1 on event, -1 on grant, saturate and flag on loss.
  always_comb begin
    cnt_nx_s  = cnt_r;
    ovf_set_s = {NUM_CH{1'b0}};
    ovf_nx_s  = overflow_r;
    for (int i = 0; i < NUM_CH; i++) begin
      case ({evt_s[i], dec_s[i]})
        2'b10: begin
          if (cnt_r[i] == CNT_MAX) begin
            cnt_nx_s[i]  = CNT_MAX;
            ovf_set_s[i] = 1'b1;
          end else begin
            cnt_nx_s[i]  = cnt_r[i] + CNT_ONE;
          end
        end
        2'b01:   cnt_nx_s[i] = cnt_r[i] - CNT_ONE;
        2'b11:   cnt_nx_s[i] = cnt_r[i];
        2'b00:   cnt_nx_s[i] = cnt_r[i];
        default: cnt_nx_s[i] = cnt_r[i];
      endcase
      // A fresh loss wins over a clear landing in the same cycle.
      if (ovf_set_s[i]) begin
        ovf_nx_s[i] = 1'b1;
      end else if (clr_overflow) begin
        ovf_nx_s[i] = 1'b0;
      end else begin
        ovf_nx_s[i] = overflow_r[i];
      end
    end
  end

  // Counter and overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {(NUM_CH * CNT_W){1'b0}};
      overflow_r <= {NUM_CH{1'b0}};
    end else begin
      cnt_r      <= cnt_nx_s;
      overflow_r <= ovf_nx_s;
    end
  end

  // Arbiter next state: offer from IDLE, hold the offer until it is taken.
  always_comb begin
    state_nx_s = state_r;
    valid_nx_s = evt_valid_r;
    ch_nx_s    = evt_ch_r;
    grant_nx_s = last_grant_r;
    ack_nx_s   = ack_tgl_r ^ dec_s;
    case (state_r)
      ST_IDLE: begin
        if (enable && found_s) begin
          state_nx_s = ST_OFFER;
          valid_nx_s = 1'b1;
          ch_nx_s    = sel_ch_s;
        end else begin
          state_nx_s = ST_IDLE;
          valid_nx_s = 1'b0;
        end
      end
      ST_OFFER: begin
        if (hs_s) begin
          state_nx_s = ST_IDLE;
          valid_nx_s = 1'b0;
          grant_nx_s = evt_ch_r;
        end else begin
          state_nx_s = ST_OFFER;
          valid_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        valid_nx_s = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered event-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      evt_valid_r  <= 1'b0;
      evt_ch_r     <= {CH_W{1'b0}};
      last_grant_r <= LAST_CH;
      ack_tgl_r    <= {NUM_CH{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      evt_valid_r  <= valid_nx_s;
      evt_ch_r     <= ch_nx_s;
      last_grant_r <= grant_nx_s;
      ack_tgl_r    <= ack_nx_s;
    end
  end

  assign evt_if.evt_valid = evt_valid_r;
  assign evt_if.evt_ch    = evt_ch_r;
  assign ack_tgl          = ack_tgl_r;
  assign overflow         = overflow_r;

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Directed bench for cdc_event_arbiter: a table of per-cycle vectors for the
// single-event latency case plus hand-written multi-cycle sequences.
module tb_cdc_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] req_tgl;
  logic [3:0] ack_tgl;
  logic [3:0] overflow;
  logic       clr_overflow;

  int n_pass;
  int n_total;

  cdc_event_arbiter_if #(.NUM_CH(4)) evt_if ();

  cdc_event_arbiter #(.NUM_CH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req_tgl      (req_tgl),
    .ack_tgl      (ack_tgl),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .evt_if       (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_ch;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    req_tgl          = 4'b0000;
    enable           = 1'b1;
    clr_overflow     = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [1:0] got_ch[8];
  int         got_cyc[8];
  int         ng;
  int         nd;

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Single event on channel 2: expected outputs after each edge.
    vecs[0] = '{req: 4'b0100, ready: 1'b1, exp_valid: 1'b0, exp_ch: 2'd0, exp_ack: 4'b0000};
    vecs[1] = '{req: 4'b0100, ready: 1'b1, exp_valid: 1'b0, exp_ch: 2'd0, exp_ack: 4'b0000};
    vecs[2] = '{req: 4'b0100, ready: 1'b1, exp_valid: 1'b0, exp_ch: 2'd0, exp_ack: 4'b0000};
    vecs[3] = '{req: 4'b0100, ready: 1'b1, exp_valid: 1'b1, exp_ch: 2'd2, exp_ack: 4'b0000};
    vecs[4] = '{req: 4'b0100, ready: 1'b1, exp_valid: 1'b0, exp_ch: 2'd2, exp_ack: 4'b0100};
    vecs[5] = '{req: 4'b0100, ready: 1'b1, exp_valid: 1'b0, exp_ch: 2'd2, exp_ack: 4'b0100};

    do_reset();
    check("reset valid", 32'(evt_if.evt_valid), 32'd0);
    check("reset ch", 32'(evt_if.evt_ch), 32'd0);
    check("reset ack", 32'(ack_tgl), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);

    for (int v = 0; v < 6; v++) begin
      req_tgl          = vecs[v].req;
      evt_if.evt_ready = vecs[v].ready;
      tick();
      check($sformatf("vec%0d {valid,ch,ack}", v),
            32'({evt_if.evt_valid, evt_if.evt_ch, ack_tgl}),
            32'({vecs[v].exp_valid, vecs[v].exp_ch, vecs[v].exp_ack}));
    end
    check("single cnt2", 32'(dut.cnt_r[2]), 32'd0);

    // Fairness: two pending events on every channel, then drain.
    do_reset();
    req_tgl = 4'b1111;
    tick();
    req_tgl = 4'b0000;
    tick();
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fair cnt%0d", i), 32'(dut.cnt_r[i]), 32'd2);
    end
    evt_if.evt_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 30; c++) begin
      if (evt_if.evt_valid) begin
        if (ng < 8) begin
          got_ch[ng]  = evt_if.evt_ch;
          got_cyc[ng] = c;
        end
        ng++;
      end
      tick();
    end
    check("fair grants", 32'(ng), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fair order%0d", k), 32'(got_ch[k]), 32'(k % 4));
      if (k > 0) begin
        check($sformatf("fair gap%0d", k), 32'(got_cyc[k] - got_cyc[k-1]), 32'd2);
      end
    end
    check("fair ack", 32'(ack_tgl), 32'd0);

    // Backpressure: channels 1 and 3 pending, consumer stalls 10 cycles.
    do_reset();
    req_tgl = 4'b1010;
    repeat (4) tick();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp hold%0d", c), 32'({evt_if.evt_valid, evt_if.evt_ch}), 32'({1'b1, 2'd1}));
      tick();
    end
    evt_if.evt_ready = 1'b1;
    tick();
    check("bp after hs", 32'({evt_if.evt_valid, ack_tgl}), 32'({1'b0, 4'b0010}));
    tick();
    check("bp next ch3", 32'({evt_if.evt_valid, evt_if.evt_ch}), 32'({1'b1, 2'd3}));
    tick();
    check("bp ack", 32'(ack_tgl), 32'({4'b1010}));

    // Saturation: nine toggles on channel 0 with the consumer stalled.
    do_reset();
    for (int t = 0; t < 9; t++) begin
      req_tgl[0] = ~req_tgl[0];
      tick();
    end
    repeat (4) tick();
    check("sat cnt0", 32'(dut.cnt_r[0]), 32'd7);
    check("sat ovf", 32'(overflow), 32'({4'b0001}));
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("sat clr", 32'(overflow), 32'd0);
    // New loss on the same edge as a clear keeps the flag set.
    req_tgl[0]   = ~req_tgl[0];
    clr_overflow = 1'b1;
    repeat (3) tick();
    clr_overflow = 1'b0;
    check("sat clr+set", 32'(overflow), 32'({4'b0001}));
    check("sat cnt0 held", 32'(dut.cnt_r[0]), 32'd7);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    evt_if.evt_ready = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        nd++;
      end
      tick();
    end
    check("sat delivered", 32'(nd), 32'd7);
    check("sat ack0", 32'(ack_tgl), 32'({4'b0001}));
    check("sat ovf end", 32'(overflow), 32'd0);

    // Simultaneous handshake and new event on channel 1.
    do_reset();
    req_tgl = 4'b0010;
    repeat (4) tick();
    check("sim offer", 32'({evt_if.evt_valid, evt_if.evt_ch}), 32'({1'b1, 2'd1}));
    req_tgl = 4'b0000;
    tick();
    tick();
    evt_if.evt_ready = 1'b1;
    tick();
    check("sim cnt1", 32'(dut.cnt_r[1]), 32'd1);
    check("sim hs", 32'({evt_if.evt_valid, ack_tgl}), 32'({1'b0, 4'b0010}));
    evt_if.evt_ready = 1'b0;
    tick();
    check("sim reoffer", 32'({evt_if.evt_valid, evt_if.evt_ch}), 32'({1'b1, 2'd1}));
    evt_if.evt_ready = 1'b1;
    tick();
    check("sim drained", 32'({dut.cnt_r[1], ack_tgl}), 32'({3'd0, 4'b0000}));

    // Enable low: toggle held in the synchronizer, delivered after enable.
    do_reset();
    enable  = 1'b0;
    req_tgl = 4'b0001;
    repeat (6) tick();
    check("en0 valid", 32'(evt_if.evt_valid), 32'd0);
    check("en0 cnt0", 32'(dut.cnt_r[0]), 32'd0);
    evt_if.evt_ready = 1'b1;
    enable           = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        nd++;
      end
      tick();
    end
    check("en1 delivered", 32'(nd), 32'd1);
    check("en1 ack", 32'(ack_tgl), 32'({4'b0001}));

    // Reset asserted while an offer is pending.
    evt_if.evt_ready = 1'b0;
    req_tgl          = 4'b0101;
    repeat (4) tick();
    check("rst offer", 32'({evt_if.evt_valid, evt_if.evt_ch}), 32'({1'b1, 2'd2}));
    rst_n   = 1'b0;
    req_tgl = 4'b0000;
    #1;
    check("rst valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst cnt", 32'(dut.cnt_r), 32'd0);
    check("rst ack", 32'(ack_tgl), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst quiet", 32'(evt_if.evt_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
